// File: rtl/easyaxi_rd_arb_pkg.sv
// Shared AXI width macros plus the read-arbiter package (AR payload struct, reset payload).
`ifndef EASY_AXI_DEFINE_V
`define EASY_AXI_DEFINE_V
`define AXI_ID_W            4
`define AXI_ADDR_W          32
`define AXI_DATA_W          32
`define AXI_LEN_W           8
`define AXI_SIZE_W          3
`define AXI_BURST_W         2
`define AXI_RESP_W          2
`define AXI_SIZE_4B         3'b010
`define AXI_BURST_FIXED     2'b00
`define EASYAXI_ARB_MAX_MST 4
`endif

package easyaxi_rd_arb_pkg;

    localparam int AXI_ID_W    = `AXI_ID_W;
    localparam int AXI_ADDR_W  = `AXI_ADDR_W;
    localparam int AXI_DATA_W  = `AXI_DATA_W;
    localparam int AXI_LEN_W   = `AXI_LEN_W;
    localparam int AXI_SIZE_W  = `AXI_SIZE_W;
    localparam int AXI_BURST_W = `AXI_BURST_W;
    localparam int AXI_RESP_W  = `AXI_RESP_W;
    localparam int ARB_MAX_MST = `EASYAXI_ARB_MAX_MST;

    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ar_pl_t;

    localparam ar_pl_t AR_PL_RST = '{
        id:    '0,
        addr:  '0,
        len:   '0,
        size:  `AXI_SIZE_4B,
        burst: `AXI_BURST_FIXED
    };

endpackage

// File: rtl/easyaxi_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, searching cyclically.
module easyaxi_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no latch is inferred.
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N))
                w_sum = w_sum - (IDX_W+1)'(N);
            w_cand = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt_idx     = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/easyaxi_rd_arb.sv
// Round-robin AXI read arbiter: NUM_MST requesters share one AR/R port, ARID prefixed with requester index.
// Optional EASYAXI_ARB_OST_LIMIT_EN caps outstanding reads per requester at MAX_OST.
module easyaxi_rd_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int IDX_W   = 1,
    parameter int MAX_OST = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_MST-1:0]                 s_arvalid,
    output logic [NUM_MST-1:0]                 s_arready,
    input  logic [NUM_MST*`AXI_ID_W-1:0]       s_arid,
    input  logic [NUM_MST*`AXI_ADDR_W-1:0]     s_araddr,
    input  logic [NUM_MST*`AXI_LEN_W-1:0]      s_arlen,
    input  logic [NUM_MST*`AXI_SIZE_W-1:0]     s_arsize,
    input  logic [NUM_MST*`AXI_BURST_W-1:0]    s_arburst,
    output logic [NUM_MST-1:0]                 s_rvalid,
    input  logic [NUM_MST-1:0]                 s_rready,
    output logic [`AXI_ID_W-1:0]               s_rid,
    output logic [`AXI_DATA_W-1:0]             s_rdata,
    output logic [`AXI_RESP_W-1:0]             s_rresp,
    output logic                               s_rlast,
    output logic                               m_arvalid,
    input  logic                               m_arready,
    output logic [IDX_W+`AXI_ID_W-1:0]         m_arid,
    output logic [`AXI_ADDR_W-1:0]             m_araddr,
    output logic [`AXI_LEN_W-1:0]              m_arlen,
    output logic [`AXI_SIZE_W-1:0]             m_arsize,
    output logic [`AXI_BURST_W-1:0]            m_arburst,
    input  logic                               m_rvalid,
    output logic                               m_rready,
    input  logic [IDX_W+`AXI_ID_W-1:0]         m_rid,
    input  logic [`AXI_DATA_W-1:0]             m_rdata,
    input  logic [`AXI_RESP_W-1:0]             m_rresp,
    input  logic                               m_rlast,
    output logic                               rsp_err
);

    localparam logic [IDX_W:0] NUM_MST_W = (IDX_W+1)'(NUM_MST);

    logic                 w_load;
    logic                 w_any;
    logic [NUM_MST-1:0]   w_elig;
    logic [NUM_MST-1:0]   w_gnt;
    logic [IDX_W-1:0]     w_gnt_idx;
    logic [IDX_W-1:0]     w_ptr_nxt;
    ar_pl_t               w_pl;
    logic [IDX_W-1:0]     w_ridx;
    logic                 w_ridx_ok;

    logic                 r_arvalid;
    ar_pl_t               r_slot;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_ptr;
    logic                 r_rsp_err;

    // The slot may refill whenever it is empty or being drained this cycle.
    assign w_load = ~r_arvalid | m_arready;

    easyaxi_rr_pick #(
        .N     (NUM_MST),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req     (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign s_arready = w_load ? w_gnt : '0;
    assign w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_MST-1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_pl = AR_PL_RST;
        for (int i = 0; i < NUM_MST; i++) begin
            if (w_gnt[i]) begin
                w_pl = '{
                    id:    s_arid[i*AXI_ID_W +: AXI_ID_W],
                    addr:  s_araddr[i*AXI_ADDR_W +: AXI_ADDR_W],
                    len:   s_arlen[i*AXI_LEN_W +: AXI_LEN_W],
                    size:  s_arsize[i*AXI_SIZE_W +: AXI_SIZE_W],
                    burst: s_arburst[i*AXI_BURST_W +: AXI_BURST_W]
                };
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arvalid <= 1'b0;
            r_slot    <= AR_PL_RST;
            r_idx     <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_arvalid <= w_any;
            if (w_any) begin
                r_slot <= w_pl;
                r_idx  <= w_gnt_idx;
                r_ptr  <= w_ptr_nxt;
            end
        end
    end

    assign m_arvalid = r_arvalid;
    assign m_arid    = {r_idx, r_slot.id};
    assign m_araddr  = r_slot.addr;
    assign m_arlen   = r_slot.len;
    assign m_arsize  = r_slot.size;
    assign m_arburst = r_slot.burst;

    // R path is pure routing on the index carried in the top RID bits.
    assign w_ridx    = m_rid[IDX_W+AXI_ID_W-1 -: IDX_W];
    assign w_ridx_ok = ({1'b0, w_ridx} < NUM_MST_W);

    always_comb begin
        s_rvalid = '0;
        for (int i = 0; i < NUM_MST; i++)
            s_rvalid[i] = m_rvalid & w_ridx_ok & (w_ridx == IDX_W'(i));
    end

    assign m_rready = w_ridx_ok ? s_rready[w_ridx] : 1'b1;
    assign s_rid    = m_rid[AXI_ID_W-1:0];
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rsp_err <= 1'b0;
        else if (m_rvalid && !w_ridx_ok)
            r_rsp_err <= 1'b1;
    end

    assign rsp_err = r_rsp_err;

`ifdef EASYAXI_ARB_OST_LIMIT_EN
    localparam int OST_W = $clog2(MAX_OST+1);

    logic [OST_W-1:0]   r_ost [NUM_MST];
    logic [NUM_MST-1:0] w_ost_full;
    logic [NUM_MST-1:0] w_ost_inc;
    logic [NUM_MST-1:0] w_ost_dec;

    always_comb begin
        w_ost_full = '0;
        for (int i = 0; i < NUM_MST; i++)
            w_ost_full[i] = (r_ost[i] == OST_W'(MAX_OST));
    end

    always_comb begin
        w_ost_inc = s_arvalid & s_arready;
        w_ost_dec = s_rvalid & s_rready & {NUM_MST{m_rlast}};
    end

    assign w_elig = s_arvalid & ~w_ost_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MST; i++)
                r_ost[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MST; i++) begin
                if (w_ost_inc[i] && !w_ost_dec[i] && !w_ost_full[i])
                    r_ost[i] <= r_ost[i] + 1'b1;
                else if (w_ost_dec[i] && !w_ost_inc[i] && (r_ost[i] != '0))
                    r_ost[i] <= r_ost[i] - 1'b1;
            end
        end
    end
`else
    assign w_elig = s_arvalid;
`endif

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Self-checking bench for easyaxi_rd_arb: directed scenarios on 2- and 3-requester instances plus a randomized scoreboard run.
module tb_easyaxi_rd_arb;
    import easyaxi_rd_arb_pkg::*;

    localparam int IW = AXI_ID_W;
    localparam int AW = AXI_ADDR_W;
    localparam int LW = AXI_LEN_W;
    localparam int SW = AXI_SIZE_W;
    localparam int BW = AXI_BURST_W;
    localparam int DW = AXI_DATA_W;
    localparam int RW = AXI_RESP_W;
    localparam int MAX_OST = 2;
    localparam logic [2:0] EXP_SIZE_4B     = 3'b010;
    localparam logic [1:0] EXP_BURST_FIXED = 2'b00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 2-requester instance
    logic [1:0]      a_arvalid = '0, a_arready;
    logic [2*IW-1:0] a_arid = '0;
    logic [2*AW-1:0] a_araddr = '0;
    logic [2*LW-1:0] a_arlen = '0;
    logic [2*SW-1:0] a_arsize = '0;
    logic [2*BW-1:0] a_arburst = '0;
    logic [1:0]      a_rvalid, a_rready = '0;
    logic [IW-1:0]   a_rid;
    logic [DW-1:0]   a_rdata;
    logic [RW-1:0]   a_rresp;
    logic            a_rlast;
    logic            a_m_arvalid, a_m_arready = 1'b0;
    logic [IW:0]     a_m_arid;
    logic [AW-1:0]   a_m_araddr;
    logic [LW-1:0]   a_m_arlen;
    logic [SW-1:0]   a_m_arsize;
    logic [BW-1:0]   a_m_arburst;
    logic            a_m_rvalid = 1'b0, a_m_rready;
    logic [IW:0]     a_m_rid = '0;
    logic [DW-1:0]   a_m_rdata = '0;
    logic [RW-1:0]   a_m_rresp = '0;
    logic            a_m_rlast = 1'b0;
    logic            a_rsp_err;

    // 3-requester instance (non power of two)
    logic [2:0]      b_arvalid = '0, b_arready;
    logic [3*IW-1:0] b_arid = '0;
    logic [3*AW-1:0] b_araddr = '0;
    logic [3*LW-1:0] b_arlen = '0;
    logic [3*SW-1:0] b_arsize = '0;
    logic [3*BW-1:0] b_arburst = '0;
    logic [2:0]      b_rvalid, b_rready = '0;
    logic [IW-1:0]   b_rid;
    logic [DW-1:0]   b_rdata;
    logic [RW-1:0]   b_rresp;
    logic            b_rlast;
    logic            b_m_arvalid, b_m_arready = 1'b0;
    logic [IW+1:0]   b_m_arid;
    logic [AW-1:0]   b_m_araddr;
    logic [LW-1:0]   b_m_arlen;
    logic [SW-1:0]   b_m_arsize;
    logic [BW-1:0]   b_m_arburst;
    logic            b_m_rvalid = 1'b0, b_m_rready;
    logic [IW+1:0]   b_m_rid = '0;
    logic [DW-1:0]   b_m_rdata = '0;
    logic [RW-1:0]   b_m_rresp = '0;
    logic            b_m_rlast = 1'b0;
    logic            b_rsp_err;

    easyaxi_rd_arb #(.NUM_MST(2), .IDX_W(1), .MAX_OST(MAX_OST)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(a_arvalid), .s_arready(a_arready), .s_arid(a_arid), .s_araddr(a_araddr),
        .s_arlen(a_arlen), .s_arsize(a_arsize), .s_arburst(a_arburst),
        .s_rvalid(a_rvalid), .s_rready(a_rready), .s_rid(a_rid), .s_rdata(a_rdata),
        .s_rresp(a_rresp), .s_rlast(a_rlast),
        .m_arvalid(a_m_arvalid), .m_arready(a_m_arready), .m_arid(a_m_arid), .m_araddr(a_m_araddr),
        .m_arlen(a_m_arlen), .m_arsize(a_m_arsize), .m_arburst(a_m_arburst),
        .m_rvalid(a_m_rvalid), .m_rready(a_m_rready), .m_rid(a_m_rid), .m_rdata(a_m_rdata),
        .m_rresp(a_m_rresp), .m_rlast(a_m_rlast), .rsp_err(a_rsp_err)
    );

    easyaxi_rd_arb #(.NUM_MST(3), .IDX_W(2), .MAX_OST(MAX_OST)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(b_arvalid), .s_arready(b_arready), .s_arid(b_arid), .s_araddr(b_araddr),
        .s_arlen(b_arlen), .s_arsize(b_arsize), .s_arburst(b_arburst),
        .s_rvalid(b_rvalid), .s_rready(b_rready), .s_rid(b_rid), .s_rdata(b_rdata),
        .s_rresp(b_rresp), .s_rlast(b_rlast),
        .m_arvalid(b_m_arvalid), .m_arready(b_m_arready), .m_arid(b_m_arid), .m_araddr(b_m_araddr),
        .m_arlen(b_m_arlen), .m_arsize(b_m_arsize), .m_arburst(b_m_arburst),
        .m_rvalid(b_m_rvalid), .m_rready(b_m_rready), .m_rid(b_m_rid), .m_rdata(b_m_rdata),
        .m_rresp(b_m_rresp), .m_rlast(b_m_rlast), .rsp_err(b_rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [LW-1:0] len, input logic [SW-1:0] size);
        a_arid[i*IW +: IW]   = id;
        a_araddr[i*AW +: AW] = addr;
        a_arlen[i*LW +: LW]  = len;
        a_arsize[i*SW +: SW] = size;
        a_arburst[i*BW +: BW] = 2'b01;
    endtask

    task automatic do_reset();
        a_arvalid = '0; a_m_arready = 1'b0; a_m_rvalid = 1'b0; a_rready = '0; a_m_rlast = 1'b0;
        b_m_rvalid = 1'b0; b_rready = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        mid();
        n_tests++; if (a_m_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_arvalid got=%0b exp=0", a_m_arvalid); end
        n_tests++; if (a_arready !== 2'b00) begin n_fail++; $display("FAIL reset_s_arready got=%b exp=00", a_arready); end
        n_tests++; if (a_m_arsize !== EXP_SIZE_4B) begin n_fail++; $display("FAIL reset_m_arsize got=%b exp=%b", a_m_arsize, EXP_SIZE_4B); end
        n_tests++; if (a_m_arburst !== EXP_BURST_FIXED) begin n_fail++; $display("FAIL reset_m_arburst got=%b exp=%b", a_m_arburst, EXP_BURST_FIXED); end
        n_tests++; if (a_m_arid !== '0 || a_m_araddr !== '0 || a_m_arlen !== '0) begin n_fail++; $display("FAIL reset_m_payload got id=%h addr=%h len=%h exp=0", a_m_arid, a_m_araddr, a_m_arlen); end
        n_tests++; if (a_rsp_err !== 1'b0 || b_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b/%b exp=0/0", a_rsp_err, b_rsp_err); end
        n_tests++; if (b_m_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_arvalid3 got=%0b exp=0", b_m_arvalid); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alternate();
        logic [AW-1:0] addr [2];
        logic [IW-1:0] id [2];
        logic [1:0]    exp_rdy;
        int            g;
        addr[0] = 32'h1000_0000; addr[1] = 32'h2000_0040;
        id[0] = 4'd3; id[1] = 4'd9;
        set_req(0, id[0], addr[0], 8'd0, EXP_SIZE_4B);
        set_req(1, id[1], addr[1], 8'd3, EXP_SIZE_4B);
        a_m_arready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_arvalid = (k < 4) ? 2'b11 : 2'b00;
            mid();
            if (k < 4) begin
                exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
                n_tests++; if (a_arready !== exp_rdy) begin n_fail++; $display("FAIL alt_s_arready cyc=%0d got=%b exp=%b", k, a_arready, exp_rdy); end
            end
            if (k > 0) begin
                g = (k - 1) % 2;
                n_tests++; if (a_m_arvalid !== 1'b1 || a_m_arid !== {1'(g), id[g]} || a_m_araddr !== addr[g]) begin
                    n_fail++; $display("FAIL alt_m_ar cyc=%0d got v=%0b id=%h addr=%h exp v=1 id=%h addr=%h", k, a_m_arvalid, a_m_arid, a_m_araddr, {1'(g), id[g]}, addr[g]);
                end
            end
            tick();
        end
        mid();
        n_tests++; if (a_m_arvalid !== 1'b0) begin n_fail++; $display("FAIL alt_drain got=%0b exp=0", a_m_arvalid); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] addr0, addr1;
        addr0 = 32'hA000_0010; addr1 = 32'hB000_0020;
        set_req(0, 4'd1, addr0, 8'd7, EXP_SIZE_4B);
        set_req(1, 4'd14, addr1, 8'd2, EXP_SIZE_4B);
        a_m_arready = 1'b0;
        a_arvalid = 2'b11;
        mid();
        n_tests++; if (a_arready !== 2'b01) begin n_fail++; $display("FAIL bp_first_grant got=%b exp=01", a_arready); end
        tick();
        a_arvalid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            mid();
            n_tests++; if (a_arready !== 2'b00) begin n_fail++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=00", k, a_arready); end
            n_tests++; if (a_m_arvalid !== 1'b1 || a_m_araddr !== addr0 || a_m_arid !== {1'b0, 4'd1}) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got v=%0b addr=%h id=%h exp v=1 addr=%h id=01", k, a_m_arvalid, a_m_araddr, a_m_arid, addr0);
            end
            tick();
        end
        a_m_arready = 1'b1;
        mid();
        n_tests++; if (a_arready !== 2'b10) begin n_fail++; $display("FAIL bp_refill_ready got=%b exp=10", a_arready); end
        tick();
        a_arvalid = 2'b00;
        mid();
        n_tests++; if (a_m_arvalid !== 1'b1 || a_m_arid !== {1'b1, 4'd14} || a_m_araddr !== addr1) begin
            n_fail++; $display("FAIL bp_no_bubble got v=%0b id=%h addr=%h exp v=1 id=1e addr=%h", a_m_arvalid, a_m_arid, a_m_araddr, addr1);
        end
        tick();
        tick();
    endtask

    task automatic test_r_route();
        logic [DW-1:0] d;
        d = $urandom();
        a_m_rvalid = 1'b1; a_m_rid = {1'b1, 4'd5}; a_m_rdata = d; a_m_rresp = 2'b10; a_m_rlast = 1'b0;
        a_rready = 2'b00;
        mid();
        n_tests++; if (a_rvalid !== 2'b10 || a_rid !== 4'd5) begin n_fail++; $display("FAIL rr_route got rvalid=%b rid=%0d exp rvalid=10 rid=5", a_rvalid, a_rid); end
        n_tests++; if (a_m_rready !== 1'b0) begin n_fail++; $display("FAIL rr_ready_low got=%0b exp=0", a_m_rready); end
        n_tests++; if (a_rdata !== d || a_rresp !== 2'b10) begin n_fail++; $display("FAIL rr_payload got data=%h resp=%b exp data=%h resp=10", a_rdata, a_rresp, d); end
        tick();
        a_rready = 2'b01;
        mid();
        n_tests++; if (a_m_rready !== 1'b0) begin n_fail++; $display("FAIL rr_wrong_ready got=%0b exp=0", a_m_rready); end
        tick();
        a_rready = 2'b10;
        mid();
        n_tests++; if (a_m_rready !== 1'b1) begin n_fail++; $display("FAIL rr_ready_high got=%0b exp=1", a_m_rready); end
        tick();
        a_m_rid = {1'b0, 4'd12}; a_rready = 2'b01;
        mid();
        n_tests++; if (a_rvalid !== 2'b01 || a_rid !== 4'd12 || a_m_rready !== 1'b1) begin
            n_fail++; $display("FAIL rr_route0 got rvalid=%b rid=%0d rready=%0b exp 01/12/1", a_rvalid, a_rid, a_m_rready);
        end
        tick();
        a_m_rvalid = 1'b0; a_rready = 2'b00;
        mid();
        n_tests++; if (a_rvalid !== 2'b00) begin n_fail++; $display("FAIL rr_idle got=%b exp=00", a_rvalid); end
        tick();
    endtask

    task automatic test_bad_idx();
        b_m_rvalid = 1'b1; b_m_rid = {2'd3, 4'd7}; b_rready = 3'b000;
        mid();
        n_tests++; if (b_m_rready !== 1'b1 || b_rvalid !== 3'b000) begin n_fail++; $display("FAIL bad_drop got rready=%0b rvalid=%b exp 1/000", b_m_rready, b_rvalid); end
        tick();
        b_m_rvalid = 1'b0;
        mid();
        n_tests++; if (b_rsp_err !== 1'b1) begin n_fail++; $display("FAIL bad_err_set got=%0b exp=1", b_rsp_err); end
        tick();
        b_m_rvalid = 1'b1; b_m_rid = {2'd2, 4'd1}; b_rready = 3'b100;
        mid();
        n_tests++; if (b_rvalid !== 3'b100 || b_m_rready !== 1'b1) begin n_fail++; $display("FAIL bad_route2 got rvalid=%b rready=%0b exp 100/1", b_rvalid, b_m_rready); end
        tick();
        b_m_rvalid = 1'b0; b_rready = 3'b000;
        tick(); tick(); tick();
        mid();
        n_tests++; if (b_rsp_err !== 1'b1 || a_rsp_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_sticky got=%0b/%0b exp=1/0", b_rsp_err, a_rsp_err); end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++; if (b_rsp_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_clear got=%0b exp=0", b_rsp_err); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ost();
        int grants, exp_grants;
        logic exp_rdy;
`ifdef EASYAXI_ARB_OST_LIMIT_EN
        exp_grants = MAX_OST;
        exp_rdy = 1'b0;
`else
        exp_grants = 3;
        exp_rdy = 1'b1;
`endif
        do_reset();
        set_req(0, 4'd6, 32'h0000_4000, 8'd0, EXP_SIZE_4B);
        a_m_arready = 1'b1;
        a_arvalid = 2'b01;
        grants = 0;
        for (int c = 0; c < 3; c++) begin
            mid();
            if (a_arready[0]) grants++;
            tick();
        end
        n_tests++; if (grants !== exp_grants) begin n_fail++; $display("FAIL ost_grant_count got=%0d exp=%0d", grants, exp_grants); end
        a_m_rvalid = 1'b1; a_m_rid = {1'b0, 4'd6}; a_m_rlast = 1'b1; a_rready = 2'b01;
        mid();
        n_tests++; if (a_arready[0] !== exp_rdy) begin n_fail++; $display("FAIL ost_blocked got=%0b exp=%0b", a_arready[0], exp_rdy); end
        tick();
        a_m_rvalid = 1'b0; a_m_rlast = 1'b0;
        mid();
        n_tests++; if (a_arready[0] !== 1'b1) begin n_fail++; $display("FAIL ost_release got=%0b exp=1", a_arready[0]); end
        tick();
        a_arvalid = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_random();
        bit            slot_v;
        logic [IW:0]   slot_id;
        logic [AW-1:0] slot_addr;
        logic [LW-1:0] slot_len;
        logic [SW-1:0] slot_size;
        int            ptr, g, rbeat, r, c;
        bit            pend [2];
        int            outst [2];
        logic [IW-1:0] q_id [2];
        logic [AW-1:0] q_addr [2];
        logic [LW-1:0] q_len [2];
        logic [SW-1:0] q_size [2];
        logic [1:0]    exp_rdy;
        bit            load, elig;
        do_reset();
        slot_v = 0; slot_id = '0; slot_addr = '0; slot_len = '0; slot_size = EXP_SIZE_4B; ptr = 0;
        for (int i = 0; i < 2; i++) begin pend[i] = 0; outst[i] = 0; end
        a_rready = 2'b11;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 3) != 0) begin
                    pend[i] = 1;
                    q_id[i] = IW'($urandom()); q_addr[i] = $urandom(); q_len[i] = LW'($urandom()); q_size[i] = SW'($urandom_range(0, 3));
                end
                set_req(i, q_id[i], q_addr[i], q_len[i], q_size[i]);
                a_arvalid[i] = pend[i];
            end
            a_m_arready = ($urandom_range(0, 3) != 0);
            rbeat = -1;
            r = $urandom_range(0, 1);
            if (outst[r] > 0 && $urandom_range(0, 1) == 1) begin
                rbeat = r;
                a_m_rvalid = 1'b1; a_m_rid = {1'(r), IW'($urandom())}; a_m_rlast = 1'b1;
            end else begin
                a_m_rvalid = 1'b0; a_m_rlast = 1'b0;
            end
            load = !slot_v || a_m_arready;
            g = -1;
            if (load) begin
                for (int k = 0; k < 2; k++) begin
                    c = (ptr + k) % 2;
`ifdef EASYAXI_ARB_OST_LIMIT_EN
                    elig = outst[c] < MAX_OST;
`else
                    elig = 1;
`endif
                    if (g < 0 && pend[c] && elig) g = c;
                end
            end
            exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
            mid();
            n_tests++; if (a_arready !== exp_rdy) begin n_fail++; $display("FAIL rnd_s_arready cyc=%0d got=%b exp=%b", cyc, a_arready, exp_rdy); end
            n_tests++; if (a_m_arvalid !== slot_v) begin n_fail++; $display("FAIL rnd_m_arvalid cyc=%0d got=%0b exp=%0b", cyc, a_m_arvalid, slot_v); end
            if (slot_v) begin
                n_tests++; if (a_m_arid !== slot_id || a_m_araddr !== slot_addr || a_m_arlen !== slot_len || a_m_arsize !== slot_size) begin
                    n_fail++; $display("FAIL rnd_m_payload cyc=%0d got id=%h addr=%h len=%h size=%h exp id=%h addr=%h len=%h size=%h",
                                       cyc, a_m_arid, a_m_araddr, a_m_arlen, a_m_arsize, slot_id, slot_addr, slot_len, slot_size);
                end
            end
            if (load) begin
                if (g >= 0) begin
                    slot_v = 1; slot_id = {1'(g), q_id[g]}; slot_addr = q_addr[g]; slot_len = q_len[g]; slot_size = q_size[g];
                    ptr = (g + 1) % 2; pend[g] = 0; outst[g]++;
                end else begin
                    slot_v = 0;
                end
            end
            if (rbeat >= 0) outst[rbeat]--;
            tick();
        end
        a_arvalid = '0; a_m_rvalid = 1'b0; a_m_rlast = 1'b0; a_m_arready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_backpressure();
        test_r_route();
        test_bad_idx();
        test_ost();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/easyaxi_rd_arb.md
Name: easyaxi_rd_arb

Overview:
- Round-robin arbiter that lets NUM_MST read masters share one downstream AXI read port (AR + R channels).
- Sits between EASYAXI master instances and a single slave or interconnect port.
- Prefixes each downstream ARID with the requester index, and uses that index to route R beats back to the right requester.

Parameters:
- NUM_MST, 2, number of upstream requesters (2..4).
- IDX_W, 1, requester index width (clog2(NUM_MST), minimum 1).
- MAX_OST, 4, per-requester outstanding read limit (used only with EASYAXI_ARB_OST_LIMIT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_arvalid  in  NUM_MST  per-requester AR valid
- s_arready  out  NUM_MST  per-requester AR ready
- s_arid  in  NUM_MST*`AXI_ID_W  packed ARIDs, requester i at slice i
- s_araddr  in  NUM_MST*`AXI_ADDR_W  packed addresses
- s_arlen  in  NUM_MST*`AXI_LEN_W  packed lengths
- s_arsize  in  NUM_MST*`AXI_SIZE_W  packed sizes
- s_arburst  in  NUM_MST*`AXI_BURST_W  packed burst types
- s_rvalid  out  NUM_MST  per-requester R valid
- s_rready  in  NUM_MST  per-requester R ready
- s_rid  out  `AXI_ID_W  R ID with index stripped (shared by all requesters)
- s_rdata  out  `AXI_DATA_W  R data (shared)
- s_rresp  out  `AXI_RESP_W  R response (shared)
- s_rlast  out  1  R last (shared)
- m_arvalid  out  1  downstream AR valid
- m_arready  in  1  downstream AR ready
- m_arid  out  IDX_W+`AXI_ID_W  {grant index, upstream ARID}
- m_araddr, m_arlen, m_arsize, m_arburst  out  AXI widths  registered AR payload
- m_rvalid  in  1  downstream R valid
- m_rready  out  1  downstream R ready
- m_rid  in  IDX_W+`AXI_ID_W  downstream RID
- m_rdata, m_rresp, m_rlast  in  AXI widths  downstream R payload
- rsp_err  out  1  sticky: R beat received with index >= NUM_MST

Behaviour:
- Reset values:
  - m_arvalid=0, m_arid=0, m_araddr=0, m_arlen=0.
  - m_arsize=`AXI_SIZE_4B, m_arburst=`AXI_BURST_FIXED.
  - Round-robin pointer=0, rsp_err=0, all outstanding counters=0.
- AR output register ("slot"):
  - `load` = ~m_arvalid | (m_arvalid & m_arready).
  - When `load` and at least one eligible s_arvalid:
    - Grant the first eligible requester at or after the pointer (cyclic search).
    - s_arready[grant]=1 combinationally in that cycle; all other s_arready=0.
    - Next edge: slot captures grant's payload, m_arid={grant, s_arid[grant]}, m_arvalid=1.
    - Pointer becomes (grant+1) mod NUM_MST.
  - When `load` and no eligible request: m_arvalid goes to 0 on the next edge; pointer unchanged.
  - Downstream handshake and a new grant in the same cycle give back-to-back transactions with no bubble. Throughput is one AR per cycle.
  - Latency: s AR handshake to m_arvalid is 1 cycle.
  - The slot payload is held stable while m_arvalid=1 and m_arready=0.
  - s_arready depends on m_arready combinationally. No path from s_arvalid to m_arvalid within a cycle.
- R routing (combinational, no storage):
  - idx = m_rid[top IDX_W bits].
  - s_rvalid[i] = m_rvalid & (idx==i).
  - m_rready = s_rready[idx].
  - s_rid = m_rid low `AXI_ID_W bits; s_rdata, s_rresp, s_rlast pass straight through.
  - idx >= NUM_MST (NUM_MST not a power of two): m_rready=1, beat dropped, all s_rvalid=0, rsp_err set until reset.
- Reset mid-operation:
  - The slot is discarded and all counters clear.
  - Downstream bursts still in flight are the system's responsibility.
- Invalid use: requesters must not change the payload while s_arvalid=1 and s_arready=0. The bench may assert this.

Optional Feature:
- Macro: EASYAXI_ARB_OST_LIMIT_EN.
- Defined:
  - Per-requester counter, width clog2(MAX_OST+1).
  - +1 on s AR handshake; -1 on s R handshake with s_rlast=1; both in the same cycle leaves it unchanged.
  - A requester whose counter equals MAX_OST is ineligible for grant.
  - The counter never exceeds MAX_OST or goes below 0.
- Undefined: no counters; every s_arvalid is eligible.

Decomposition:
- Shared package/define file (easy_axi_define.v):
  - AXI width macros, `AXI_SIZE_4B, `AXI_BURST_FIXED.
  - New `EASYAXI_ARB_MAX_MST = 4.
- Sub-module easyaxi_rr_pick:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any-grant.
  - Purely combinational; reusable by a future AW arbiter.

Test Plan:
1. Reset with all inputs idle: m_arvalid=0, s_arready=0, m_arsize=`AXI_SIZE_4B, m_arburst=`AXI_BURST_FIXED, rsp_err=0.
2. Requesters 0 and 1 both hold arvalid, m_arready=1, NUM_MST=2: grants alternate 0,1,0,1 on consecutive cycles. m_arid[top]=0,1,0,1 and m_araddr matches each requester's address.
3. m_arready=0 for 3 cycles with the slot full: m_araddr and m_arid stable, s_arready=0. Drop m_arready low then high: the next grant loads in the same handshake cycle, no bubble.
4. m_rvalid with m_rid={1,ID 5}, s_rready[1]=0 then 1: s_rvalid=2'b10, s_rid=5, m_rready follows s_rready[1].
5. NUM_MST=3, m_rid index=3: m_rready=1, s_rvalid=0, rsp_err=1 and stays 1 until rst_n low.
6. With EASYAXI_ARB_OST_LIMIT_EN, MAX_OST=2: requester 0 issues 2 ARs and gets no third grant until an R beat with rlast=1 reaches it. Without the macro, a third grant occurs.
